// File: rtl/lut_dm_stream_if.sv
// Request/beat/config bundle for lut_dm_stream.
// slave is the table side; master is whatever drives requests and config.
interface lut_dm_stream_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 10
);
    logic          Req_valid;
    logic          Req_ready;
    logic [W-1:0]  MuxReg;
    logic [W-1:0]  EntryReg;
    logic [W-1:0]  Burst_len;
    logic          Tgt_valid;
    logic          Tgt_ready;
    logic [AW-1:0] Target;
    logic          Err;
    logic          Busy;
    logic          Cfg_we;
    logic [W-1:0]  Cfg_bank;
    logic [W-1:0]  Cfg_entry;
    logic [AW-1:0] Cfg_data;

    modport master (
        output Req_valid, MuxReg, EntryReg, Burst_len, Tgt_ready,
               Cfg_we, Cfg_bank, Cfg_entry, Cfg_data,
        input  Req_ready, Tgt_valid, Target, Err, Busy
    );

    modport slave (
        input  Req_valid, MuxReg, EntryReg, Burst_len, Tgt_ready,
               Cfg_we, Cfg_bank, Cfg_entry, Cfg_data,
        output Req_ready, Tgt_valid, Target, Err, Busy
    );
endinterface

// File: rtl/lut_dm_stream.sv
// Programmable (bank, entry) -> data-memory address table.
// Streams consecutive-entry addresses, wrapping within the bank, under valid/ready.
module lut_dm_stream #(
    parameter int unsigned W       = 8,
    parameter int unsigned AW      = 10,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned BANKS   = 2,
    parameter int unsigned BASE    = 72
) (
    input  logic           Clk,
    input  logic           Reset,
    lut_dm_stream_if.slave bus
);
    localparam int unsigned EW = $clog2(ENTRIES);
    localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [W:0] BANKS_LIM   = (W+1)'(BANKS);
    localparam logic [W:0] ENTRIES_LIM = (W+1)'(ENTRIES);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state, state_next;
    logic [AW-1:0] tbl [BANKS][ENTRIES];
    logic [BW-1:0] bank;
    logic [EW-1:0] ptr;
    logic [W-1:0]  remaining;
    logic          tgt_valid;
    logic          err;
    logic [AW-1:0] target;

    logic          accept, handshake, last_beat, req_ready, busy;
    logic          req_oor, cfg_ok;
    logic [BW-1:0] req_bank;
    logic [EW-1:0] req_entry, ptr_next;

    assign req_oor   = ({1'b0, bus.MuxReg} >= BANKS_LIM) || ({1'b0, bus.EntryReg} >= ENTRIES_LIM);
    assign cfg_ok    = bus.Cfg_we && ({1'b0, bus.Cfg_bank} < BANKS_LIM)
                                  && ({1'b0, bus.Cfg_entry} < ENTRIES_LIM);
    assign req_bank  = bus.MuxReg[BW-1:0];
    assign req_entry = bus.EntryReg[EW-1:0];
    assign ptr_next  = ptr + EW'(1);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        handshake  = 1'b0;
        last_beat  = 1'b0;
        req_ready  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.Req_valid) begin
                    accept     = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                handshake = tgt_valid && bus.Tgt_ready;
                last_beat = (remaining == W'(1));
                if (handshake && last_beat) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Table reads use pre-write contents, so a beat registered alongside a write
    // to its own entry carries the old address.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int unsigned b = 0; b < BANKS; b++)
                for (int unsigned e = 0; e < ENTRIES; e++)
                    tbl[b][e] <= AW'(BASE + b*ENTRIES + e);
            tgt_valid <= 1'b0;
            target    <= '0;
            err       <= 1'b0;
            bank      <= '0;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            if (accept) begin
                tgt_valid <= 1'b1;
                bank      <= req_bank;
                ptr       <= req_entry;
                if (req_oor) begin
                    err       <= 1'b1;
                    target    <= '0;
                    remaining <= W'(1);
                end else begin
                    err       <= 1'b0;
                    target    <= tbl[req_bank][req_entry];
                    remaining <= (bus.Burst_len == '0) ? W'(1) : bus.Burst_len;
                end
            end else if (handshake) begin
                if (last_beat) begin
                    tgt_valid <= 1'b0;
                end else begin
                    remaining <= remaining - W'(1);
                    ptr       <= ptr_next;
                    target    <= tbl[bank][ptr_next];
                end
            end
            if (cfg_ok)
                tbl[bus.Cfg_bank[BW-1:0]][bus.Cfg_entry[EW-1:0]] <= bus.Cfg_data;
        end
    end

    assign bus.Req_ready = req_ready;
    assign bus.Busy      = busy;
    assign bus.Tgt_valid = tgt_valid;
    assign bus.Target    = target;
    assign bus.Err       = err;
endmodule

// File: tb/tb_lut_dm_stream.sv
// Bench for lut_dm_stream: a queue-of-beats reference model checked every cycle,
// directed scenarios pinned with literal address sequences, then random traffic.
module tb_lut_dm_stream;
    localparam int W = 8, AW = 10, ENTRIES = 16, BANKS = 2, BASE = 72;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    lut_dm_stream_if #(.W(W), .AW(AW)) bus ();

    lut_dm_stream #(.W(W), .AW(AW), .ENTRIES(ENTRIES), .BANKS(BANKS), .BASE(BASE)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: table contents plus the list of beats still owed.
    int tab [BANKS][ENTRIES];
    int beats[$];
    bit m_valid, m_err, m_busy;
    int m_target;

    int obs_t[$];
    int obs_e[$];
    int exp_q[$];
    bit cmp_en = 0;
    int ready_mode = 0;
    int alt = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        int mb, me, n, cb, ce;
        if (!Reset) begin
            for (int b = 0; b < BANKS; b++)
                for (int e = 0; e < ENTRIES; e++)
                    tab[b][e] = (BASE + b*ENTRIES + e) % (1 << AW);
            m_valid = 0; m_err = 0; m_target = 0; m_busy = 0;
            beats.delete();
        end else begin
            if (m_busy) begin
                if (m_valid && bus.Tgt_ready) begin
                    void'(beats.pop_front());
                    if (beats.size() == 0) begin
                        m_valid = 0;
                        m_busy = 0;
                    end else begin
                        m_target = tab[beats[0] / ENTRIES][beats[0] % ENTRIES];
                    end
                end
            end else if (bus.Req_valid) begin
                mb = int'(bus.MuxReg);
                me = int'(bus.EntryReg);
                m_busy = 1;
                m_valid = 1;
                if (mb >= BANKS || me >= ENTRIES) begin
                    m_err = 1;
                    m_target = 0;
                    beats.push_back(-1);
                end else begin
                    n = (bus.Burst_len == 0) ? 1 : int'(bus.Burst_len);
                    for (int i = 0; i < n; i++)
                        beats.push_back(mb*ENTRIES + (me + i) % ENTRIES);
                    m_err = 0;
                    m_target = tab[mb][me];
                end
            end
            cb = int'(bus.Cfg_bank);
            ce = int'(bus.Cfg_entry);
            if (bus.Cfg_we && cb < BANKS && ce < ENTRIES)
                tab[cb][ce] = int'(bus.Cfg_data);
        end
    endtask

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("req_ready", int'(bus.Req_ready), int'(!m_busy));
            chk("busy", int'(bus.Busy), int'(m_busy));
            chk("tgt_valid", int'(bus.Tgt_valid), int'(m_valid));
            if (m_valid) begin
                chk("target", int'(bus.Target), m_target);
                chk("err", int'(bus.Err), int'(m_err));
            end
            if (bus.Tgt_valid && bus.Tgt_ready) begin
                obs_t.push_back(int'(bus.Target));
                obs_e.push_back(int'(bus.Err));
            end
        end
    end

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic set_ready();
        case (ready_mode)
            0: bus.Tgt_ready = 1'b1;
            1: begin bus.Tgt_ready = alt[0]; alt++; end
            default: bus.Tgt_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic drain();
        int n = 0;
        while (m_busy && n < 2000) begin
            set_ready();
            cycle();
            n++;
        end
        if (m_busy) chk("burst_timeout", 1, 0);
    endtask

    task automatic do_req(int b, int e, int len);
        obs_t.delete();
        obs_e.delete();
        drain();
        bus.Req_valid = 1'b1;
        bus.MuxReg    = W'(b);
        bus.EntryReg  = W'(e);
        bus.Burst_len = W'(len);
        set_ready();
        cycle();
        bus.Req_valid = 1'b0;
        bus.Cfg_we    = 1'b0;
        drain();
    endtask

    task automatic cfg_write(int b, int e, int d);
        bus.Cfg_we    = 1'b1;
        bus.Cfg_bank  = W'(b);
        bus.Cfg_entry = W'(e);
        bus.Cfg_data  = AW'(d);
        set_ready();
        cycle();
        bus.Cfg_we = 1'b0;
    endtask

    task automatic check_obs(string name);
        chk({name, "_count"}, obs_t.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_t.size(); i++)
            chk(name, obs_t[i], exp_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Req_valid = 0; bus.MuxReg = '0; bus.EntryReg = '0; bus.Burst_len = '0;
        bus.Tgt_ready = 0; bus.Cfg_we = 0; bus.Cfg_bank = '0; bus.Cfg_entry = '0;
        bus.Cfg_data = '0;
        Reset = 1'b0;
        cycle();
        cycle();
        cmp_en = 1;
        @(negedge Clk);
        chk("rst_req_ready", int'(bus.Req_ready), 1);
        chk("rst_tgt_valid", int'(bus.Tgt_valid), 0);
        chk("rst_target", int'(bus.Target), 0);
        chk("rst_err", int'(bus.Err), 0);
        chk("rst_busy", int'(bus.Busy), 0);
        Reset = 1'b1;

        ready_mode = 0;
        do_req(0, 5, 0);
        exp_q = {77}; check_obs("single_0_5");
        do_req(1, 15, 1);
        exp_q = {103}; check_obs("single_1_15");

        for (int i = 0; i < BANKS*ENTRIES; i++) begin
            do_req(i / ENTRIES, i % ENTRIES, 1);
            exp_q = {72 + i}; check_obs("sweep");
        end

        do_req(0, 14, 4);
        exp_q = {86, 87, 72, 73}; check_obs("burst_wrap");
        ready_mode = 1; alt = 0;
        do_req(0, 14, 4);
        exp_q = {86, 87, 72, 73}; check_obs("burst_stall");
        ready_mode = 0;

        cfg_write(1, 2, 500);
        do_req(1, 2, 1);
        exp_q = {500}; check_obs("cfg_500");
        cfg_write(2, 0, 7);
        do_req(0, 0, 1);
        exp_q = {72}; check_obs("cfg_oor_ignored");
        do_req(2, 0, 3);
        exp_q = {0}; check_obs("err_bank");
        if (obs_e.size() > 0) chk("err_bank_flag", obs_e[0], 1);
        do_req(0, 16, 2);
        exp_q = {0}; check_obs("err_entry");

        // Write to the first beat's own entry on the acceptance edge.
        bus.Cfg_we = 1'b1; bus.Cfg_bank = 0; bus.Cfg_entry = 3; bus.Cfg_data = AW'(999);
        do_req(0, 3, 3);
        exp_q = {75, 76, 77}; check_obs("write_same_edge");
        do_req(0, 3, 1);
        exp_q = {999}; check_obs("write_later");

        obs_t.delete();
        bus.Req_valid = 1'b1; bus.MuxReg = 0; bus.EntryReg = 0; bus.Burst_len = 8;
        set_ready();
        cycle();
        bus.Req_valid = 1'b0;
        cycle();
        Reset = 1'b0;
        cycle();
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_tgt_valid", int'(bus.Tgt_valid), 0);
        chk("abort_busy", int'(bus.Busy), 0);
        do_req(1, 2, 1);
        exp_q = {90}; check_obs("table_restored");

        ready_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            bus.Req_valid = ($urandom_range(0, 3) == 0);
            bus.MuxReg    = W'($urandom_range(0, 2));
            bus.EntryReg  = W'($urandom_range(0, 17));
            bus.Burst_len = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                        : W'($urandom_range(0, 5));
            bus.Cfg_we    = ($urandom_range(0, 3) == 0);
            bus.Cfg_bank  = W'($urandom_range(0, 2));
            bus.Cfg_entry = W'($urandom_range(0, 17));
            bus.Cfg_data  = AW'($urandom_range(0, 1023));
            Reset         = ($urandom_range(0, 199) != 0);
            set_ready();
            cycle();
        end
        bus.Req_valid = 1'b0;
        bus.Cfg_we = 1'b0;
        Reset = 1'b1;
        drain();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lut_dm_stream.md
Name: lut_dm_stream

Overview:
- Parametrised, programmable successor to the two-bank data-memory address LUT.
- Maps a (bank, entry) register pair to a data-memory address from an internal writable table.
- Can emit a burst of consecutive-entry addresses under a valid/ready handshake.
- Sits between the register file outputs and the data-memory address mux, feeding Target to data memory.

Parameters:
- W, 8, data path width of bank/entry/length inputs
- AW, 10, data-memory address width (Target, Cfg_data)
- ENTRIES, 16, entries per bank (power of two, >=2)
- BANKS, 2, number of banks (>=1, <=2^W)
- BASE, 72, default address of bank 0 entry 0

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- Req_valid  in  1  lookup/burst request
- Req_ready  out  1  request accepted when Req_valid & Req_ready
- MuxReg  in  W  bank select
- EntryReg  in  W  starting entry
- Burst_len  in  W  beats requested; 0 treated as 1
- Tgt_valid  out  1  Target/Err valid
- Tgt_ready  in  1  consumer accepts beat
- Target  out  AW  data-memory address
- Err  out  1  request out of range (valid with Tgt_valid)
- Busy  out  1  burst in progress
- Cfg_we  in  1  table write enable
- Cfg_bank  in  W  table write bank
- Cfg_entry  in  W  table write entry
- Cfg_data  in  AW  table write data

Behaviour:
- Reset (Reset==0 at an edge, any state):
  - Table[b][e] = BASE + b*ENTRIES + e, truncated to AW. Defaults reproduce 72..103 for default parameters.
  - Tgt_valid=0, Target=0, Err=0, Busy=0, state IDLE. Req_ready=1 from the following cycle.
  - A burst in flight is aborted; no further beats.
- FSM states:
  - IDLE: Req_ready=1, Busy=0.
  - STREAM: Req_ready=0, Busy=1.
- IDLE -> STREAM on Req_valid at an edge. Captures:
  - bank = MuxReg, ptr = EntryReg, remaining = max(Burst_len,1).
  - Tgt_valid=1 from the next cycle: 1-cycle latency from request acceptance.
- Range check at acceptance: if MuxReg>=BANKS or EntryReg>=ENTRIES:
  - Emit a single beat with Err=1, Target=0, regardless of Burst_len.
  - Return to IDLE on its handshake.
- Beat contents: Target = Table[bank][ptr] registered; Err=0.
- After each handshake (Tgt_valid & Tgt_ready):
  - ptr = (ptr+1) mod ENTRIES, wrapping within the same bank; remaining decrements.
  - Next beat is valid the following cycle, giving 1 beat/cycle under continuous Tgt_ready.
- Last beat handshake: Tgt_valid=0 next cycle, STREAM -> IDLE. At least one idle cycle between bursts.
- Backpressure: while Tgt_valid & !Tgt_ready, Target, Err and ptr hold stable; no beat is dropped or repeated.
- Config writes:
  - Cfg_we at an edge writes Table[Cfg_bank][Cfg_entry] = Cfg_data, in any state.
  - Out-of-range bank/entry: write ignored.
  - A beat registered at the same edge as a write to its own entry takes the old value. A held beat keeps its already-registered value.
  - Later beats see the new value.
- Reset has priority over Cfg_we and Req_valid.
- Burst_len up to 2^W-1; remaining counter is W bits and never underflows.

Test Plan:
- Reset, then single request MuxReg=0, EntryReg=5, Burst_len=0, Tgt_ready=1 -> Tgt_valid one cycle after acceptance, Target=77, Err=0, back to IDLE (Req_ready=1) after handshake.
- MuxReg=1, EntryReg=15, Burst_len=1 -> Target=103. Sweep all 32 pairs -> 72..103 in order.
- Burst MuxReg=0, EntryReg=14, Burst_len=4, Tgt_ready=1 -> Targets 86,87,72,73 on 4 consecutive cycles, Busy=1 throughout, wrap stays in bank 0.
- Same burst with Tgt_ready low on alternate cycles -> each Target held while stalled, sequence 86,87,72,73 exactly once each.
- Cfg_we bank=1, entry=2, data=500, then request (1,2) -> Target=500. Write (2,0) -> ignored. Request MuxReg=2 -> single beat Err=1, Target=0.
- Reset asserted during beat 2 of an 8-beat burst -> Tgt_valid=0, Busy=0 next cycle, table back to defaults (request (1,2) -> 90).
